// File: rtl/boot_loader.sv
// ============================================================================
// Module   : boot_loader
// Purpose  : Loads a framed byte stream into instruction memory, then releases
//            the core's active-low reset after a verified checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         RAM_AMOUNT  = 32,
    parameter int         HOLD_CYCLES = 2,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rx_ready,
    output logic                  o_mem_we,
    output logic [31:0]           o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic [3:0]            o_mem_ctrl,
    output logic                  o_init_active,
    output logic                  o_core_rst_n,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int          c_hcnt_w     = $clog2(HOLD_CYCLES) + 1;
    localparam logic [15:0] c_ram_amount = 16'(RAM_AMOUNT);
    localparam logic [c_hcnt_w-1:0] c_hcnt_last = c_hcnt_w'(HOLD_CYCLES - 1);

    localparam logic [3:0] c_st_sync  = 4'd0;
    localparam logic [3:0] c_st_len0  = 4'd1;
    localparam logic [3:0] c_st_len1  = 4'd2;
    localparam logic [3:0] c_st_data  = 4'd3;
    localparam logic [3:0] c_st_csum  = 4'd4;
    localparam logic [3:0] c_st_hold  = 4'd5;
    localparam logic [3:0] c_st_run   = 4'd6;
    localparam logic [3:0] c_st_error = 4'd7;

    logic [3:0]            r_state,     w_state_nxt;
    logic [15:0]           r_cnt,       w_cnt_nxt;
    logic [7:0]            r_csum,      w_csum_nxt;
    logic [15:0]           r_widx,      w_widx_nxt;
    logic [1:0]            r_bidx,      w_bidx_nxt;
    logic [31:0]           r_word,      w_word_nxt;
    logic [c_hcnt_w-1:0]   r_hcnt,      w_hcnt_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic [31:0]           r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_data,  w_mem_data_nxt;
    logic                  r_rx_ready;
    logic                  r_init_active;
    logic                  r_core_rst_n;
    logic                  r_done;
    logic                  r_error;

    logic                  w_xfer;
    logic [15:0]           w_len;
    logic [31:0]           w_word_asm;

    assign w_xfer = i_rx_valid & r_rx_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_csum_nxt     = r_csum;
        w_widx_nxt     = r_widx;
        w_bidx_nxt     = r_bidx;
        w_word_nxt     = r_word;
        w_hcnt_nxt     = r_hcnt;
        w_mem_we_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        w_len          = {i_rx_data, r_cnt[7:0]};
        w_word_asm     = r_word;
        w_word_asm[8*r_bidx +: 8] = i_rx_data;

        case (r_state)
            c_st_sync: begin
                if (w_xfer && (i_rx_data == SYNC_BYTE)) begin
                    w_state_nxt = c_st_len0;
                    w_csum_nxt  = 8'h00;
                end
            end
            c_st_len0: begin
                if (w_xfer) begin
                    w_cnt_nxt   = {r_cnt[15:8], i_rx_data};
                    w_csum_nxt  = r_csum ^ i_rx_data;
                    w_state_nxt = c_st_len1;
                end
            end
            c_st_len1: begin
                if (w_xfer) begin
                    w_cnt_nxt  = w_len;
                    w_csum_nxt = r_csum ^ i_rx_data;
                    if (w_len > c_ram_amount) begin
                        w_state_nxt = c_st_error;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = c_st_csum;
                    end else begin
                        w_state_nxt = c_st_data;
                        w_widx_nxt  = 16'd0;
                        w_bidx_nxt  = 2'd0;
                    end
                end
            end
            c_st_data: begin
                if (w_xfer) begin
                    w_word_nxt = w_word_asm;
                    w_csum_nxt = r_csum ^ i_rx_data;
                    w_bidx_nxt = r_bidx + 2'd1;
                    if (r_bidx == 2'd3) begin
                        // Write uses the assembled word including the byte arriving now.
                        w_mem_we_nxt   = 1'b1;
                        w_mem_addr_nxt = {16'd0, r_widx};
                        w_mem_data_nxt = w_word_asm;
                        w_widx_nxt     = r_widx + 16'd1;
                        if (r_widx == (r_cnt - 16'd1)) begin
                            w_state_nxt = c_st_csum;
                        end
                    end
                end
            end
            c_st_csum: begin
                if (w_xfer) begin
                    if (i_rx_data == r_csum) begin
                        w_state_nxt = c_st_hold;
                        w_hcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = c_st_error;
                    end
                end
            end
            c_st_hold: begin
                w_hcnt_nxt = r_hcnt + 1'b1;
                if (r_hcnt == c_hcnt_last) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run:   w_state_nxt = c_st_run;
            c_st_error: w_state_nxt = c_st_error;
            default:    w_state_nxt = c_st_error;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_sync;
            r_cnt         <= 16'd0;
            r_csum        <= 8'h00;
            r_widx        <= 16'd0;
            r_bidx        <= 2'd0;
            r_word        <= 32'd0;
            r_hcnt        <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_data    <= '0;
            r_rx_ready    <= 1'b0;
            r_init_active <= 1'b1;
            r_core_rst_n  <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_csum        <= w_csum_nxt;
            r_widx        <= w_widx_nxt;
            r_bidx        <= w_bidx_nxt;
            r_word        <= w_word_nxt;
            r_hcnt        <= w_hcnt_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_data    <= w_mem_data_nxt;
            r_rx_ready    <= (w_state_nxt <= c_st_csum);
            r_init_active <= (w_state_nxt != c_st_run);
            r_core_rst_n  <= (w_state_nxt == c_st_run);
            r_done        <= (w_state_nxt == c_st_run);
            r_error       <= (w_state_nxt == c_st_error);
        end
    end

    assign o_rx_ready    = r_rx_ready;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data    = r_mem_data;
    assign o_mem_ctrl    = 4'b1111;
    assign o_init_active = r_init_active;
    assign o_core_rst_n  = r_core_rst_n;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// Module   : tb_boot_loader
// Purpose  : Directed self-checking bench for boot_loader framing and timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_rx_ready;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_ctrl;
    logic        o_init_active;
    logic        o_core_rst_n;
    logic        o_done;
    logic        o_error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  tx_q[$];
    int          base;

    boot_loader #(
        .DATA_WIDTH (32),
        .RAM_AMOUNT (32),
        .HOLD_CYCLES(2),
        .SYNC_BYTE  (8'hA5)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_rx_ready   (o_rx_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_ctrl   (o_mem_ctrl),
        .o_init_active(o_init_active),
        .o_core_rst_n (o_core_rst_n),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_mem_we === 1'b1) begin
            wr_addr.push_back(o_mem_addr);
            wr_data.push_back(o_mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_rx_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        base = wr_addr.size();
    endtask

    // Presents one byte and holds it until the edge where ready accepts it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        waited = 0;
        while (o_rx_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 100) check("rx_ready_timeout", {31'd0, o_rx_ready}, 32'd1);
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_q(input int max_gap);
        foreach (tx_q[i]) send_byte(tx_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    function automatic logic [31:0] wr_at(input int idx, input bit is_addr);
        if (idx >= wr_addr.size()) return 32'hxxxx_xxxx;
        return is_addr ? wr_addr[idx] : wr_data[idx];
    endfunction

    task automatic check_good_load(input string pfx);
        check({pfx, "_wr_count"}, 32'(wr_addr.size() - base), 32'd2);
        check({pfx, "_wr0_addr"}, wr_at(base, 1'b1), 32'd0);
        check({pfx, "_wr0_data"}, wr_at(base, 1'b0), 32'h1234_5678);
        check({pfx, "_wr1_addr"}, wr_at(base + 1, 1'b1), 32'd1);
        check({pfx, "_wr1_data"}, wr_at(base + 1, 1'b0), 32'hDEAD_BEEF);
        // Checksum byte accepted on edge 1; RUN entered on edge 3.
        check({pfx, "_rstn_edge1"}, {31'd0, o_core_rst_n}, 32'd0);
        @(posedge clk); #1;
        check({pfx, "_rstn_edge2"}, {31'd0, o_core_rst_n}, 32'd0);
        check({pfx, "_done_edge2"}, {31'd0, o_done}, 32'd0);
        @(posedge clk); #1;
        check({pfx, "_rstn_edge3"}, {31'd0, o_core_rst_n}, 32'd1);
        check({pfx, "_done_edge3"}, {31'd0, o_done}, 32'd1);
        check({pfx, "_init_active"}, {31'd0, o_init_active}, 32'd0);
        check({pfx, "_rx_ready"}, {31'd0, o_rx_ready}, 32'd0);
        check({pfx, "_error"}, {31'd0, o_error}, 32'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rx_ready"}, {31'd0, o_rx_ready}, 32'd0);
        check({pfx, "_mem_we"}, {31'd0, o_mem_we}, 32'd0);
        check({pfx, "_mem_addr"}, o_mem_addr, 32'd0);
        check({pfx, "_mem_data"}, o_mem_data, 32'd0);
        check({pfx, "_mem_ctrl"}, {28'd0, o_mem_ctrl}, 32'hF);
        check({pfx, "_init_active"}, {31'd0, o_init_active}, 32'd1);
        check({pfx, "_core_rst_n"}, {31'd0, o_core_rst_n}, 32'd0);
        check({pfx, "_done"}, {31'd0, o_done}, 32'd0);
        check({pfx, "_error"}, {31'd0, o_error}, 32'd0);
    endtask

    initial begin
        // Reset values, then ready rises once reset is released
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_reset_values("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", {31'd0, o_rx_ready}, 32'd1);
        base = wr_addr.size();

        // Good two-word frame
        tx_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        send_q(0);
        check_good_load("load");

        // Bad checksum
        do_reset();
        tx_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
        send_q(0);
        check("badcs_error", {31'd0, o_error}, 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("badcs_error_sticky", {31'd0, o_error}, 32'd1);
        check("badcs_core_rst_n", {31'd0, o_core_rst_n}, 32'd0);
        check("badcs_rx_ready", {31'd0, o_rx_ready}, 32'd0);
        check("badcs_done", {31'd0, o_done}, 32'd0);
        check("badcs_init_active", {31'd0, o_init_active}, 32'd1);

        // Word count above memory depth
        do_reset();
        tx_q = {8'hA5, 8'h21, 8'h00};
        send_q(0);
        check("ovf_error", {31'd0, o_error}, 32'd1);
        check("ovf_rx_ready", {31'd0, o_rx_ready}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("ovf_wr_count", 32'(wr_addr.size() - base), 32'd0);

        // Leading junk, empty frame, random valid gaps
        do_reset();
        tx_q = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_q(3);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("empty_done", {31'd0, o_done}, 32'd1);
        check("empty_core_rst_n", {31'd0, o_core_rst_n}, 32'd1);
        check("empty_error", {31'd0, o_error}, 32'd0);
        check("empty_wr_count", 32'(wr_addr.size() - base), 32'd0);

        // Abort mid-load, then full reload
        do_reset();
        tx_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
        send_q(0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("abort");
        do_reset();
        tx_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        send_q(0);
        check_good_load("reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
